i2c_reg_access_ctrl: RTL and testbench
======================================

# i2c_reg_access_ctrl

Command sequencer for the byte-level I2C master. Accepts one register-access request at a time (7-bit device address, 8-bit register address, optional write byte) and drives the master's CMD/tx_data strobes through the full START / WRITE / RESTART / READ / STOP sequence. It returns read data or an error. It sits between the AXI/register front end and the I2C master, so software issues whole transactions rather than individual bus conditions.

## Interface
- TIMEOUT_CYC, 20000: max clk cycles allowed per master step before abort (one byte ≈ 9250 cycles).
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request; high only in S_IDLE.
- req_rw  in  1  0 = register write, 1 = register read.
- req_dev_addr  in  7  target device address.
- req_reg_addr  in  8  target register address.
- req_wdata  in  8  write byte (ignored for reads).
- resp_valid  out  1  one-cycle pulse: transaction finished.
- resp_err  out  1  valid with resp_valid; 1 = step timeout.
- resp_rdata  out  8  read byte; held until the next read completes.
- busy  out  1  high from accept through the resp_valid cycle.
- m_cmd  out  4  to master CMD: 0 idle, 1 START, 2 STOP, 3 RESTART, 4 RD, 5 WR.
- m_tx_data  out  8  to master tx_data.
- m_ready  in  1  from master ready.
- m_rx_data  in  8  from master rx_data.
- m_abort  out  1  one-cycle pulse on timeout; ORed into the master reset at top level.

## Operation
- Accept on req_valid & req_ready. Latch rw, dev_addr, reg_addr, wdata. Clear step index.
- Write step list: 0 START, 1 WR {dev,0}, 2 WR reg, 3 WR wdata, 4 STOP.
- Read step list: 0 START, 1 WR {dev,0}, 2 WR reg, 3 RESTART, 4 WR {dev,1}, 5 RD (last).
- No STOP is issued after RD. The master releases SDA for the ACK slot (NACK) and stops by itself. The controller only waits for m_ready.
- States:
  - S_IDLE: req_ready=1. Go to S_ISSUE on accept.
  - S_ISSUE: wait for m_ready=1. In the first cycle m_ready=1, drive m_cmd/m_tx_data for exactly that cycle, then go to S_WAIT_ACC. Otherwise m_cmd=0.
  - S_WAIT_ACC: m_cmd=0. Wait for m_ready=0, meaning the master left IDLE/HOLD. Then go to S_WAIT_DONE.
  - S_WAIT_DONE: wait for m_ready=1. If the step was RD, capture m_rx_data into resp_rdata in that cycle. If the step was last, go to S_RESP; else increment the index and go to S_ISSUE.
  - S_RESP: resp_valid=1 for one cycle, resp_err=0. Return to S_IDLE.
  - S_ABORT: resp_valid=1, resp_err=1, m_abort=1 for one cycle. Return to S_IDLE. resp_rdata is unchanged.
- m_tx_data holds its last value outside the issue cycle. Only m_cmd is gated.
- Step timer:
  - Cleared on entry to S_ISSUE. Counts in S_ISSUE, S_WAIT_ACC and S_WAIT_DONE.
  - Reaching TIMEOUT_CYC-1 in any of those states goes to S_ABORT.
  - This covers a slave NACK: the master auto-STOPs to IDLE, ignores the next WR, m_ready never drops, and the timer expires.
- Width: timer is $clog2(TIMEOUT_CYC) bits; step index is 3 bits.

## Timing
- Reset values: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, busy=0, m_cmd=0, m_tx_data=0, m_abort=0, state S_IDLE.
- Accept-to-first-command: 1 cycle if m_ready=1.
- m_cmd is nonzero for exactly one cycle per step, and only when m_ready=1 in that same cycle.
- Write transaction latency ≈ 500+1000 (START) + 3×9250 + 501 (STOP) + ~12 controller cycles.
- resp_valid follows the final m_ready rise by exactly 1 cycle.
- req_valid during busy is ignored; there is no queueing.
- Reset asserted mid-transaction returns the controller to S_IDLE next cycle with no resp_valid. The master is reset by the same signal.
- m_ready already 1 on entering S_WAIT_DONE cannot occur, because S_WAIT_ACC requires a 0 first.

## Test plan
- Write dev=0x50 reg=0x10 data=0xA5 with ACKing slave model -> bus shows START, 0xA0, 0x10, 0xA5, STOP; one resp_valid, resp_err=0; m_cmd sequence 1,5,5,5,2.
- Read dev=0x50 reg=0x20, slave returns 0x3C -> bytes 0xA0, 0x20, RESTART, 0xA1; resp_rdata=0x3C, resp_err=0; no STOP command issued (m_cmd sequence 1,5,5,3,5,4).
- Absent device (slave never ACKs byte 0xA0), TIMEOUT_CYC=20000 -> master auto-STOPs; resp_valid with resp_err=1 and m_abort pulse ≤20000 cycles after the WR reg issue; resp_rdata unchanged.
- req_valid held high through completion with a second request -> second accepted only in the cycle after resp_valid; req_ready=0 throughout the first.
- Reset pulsed during step 3 of a write -> next cycle: state idle, all outputs at reset values, no resp_valid; a fresh request then completes normally.
- Back-to-back read then write -> resp_rdata from the read persists through the write's resp_valid.

Source files
------------

// File: rtl/i2c_reg_access_ctrl_if.sv
// Request/response and byte-master strobe bundle for the register-access sequencer.
// "slave" is the sequencer's view; "master" is the environment (front end + I2C master).
interface i2c_reg_access_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_rw;
    logic [6:0] req_dev_addr;
    logic [7:0] req_reg_addr;
    logic [7:0] req_wdata;
    logic       resp_valid;
    logic       resp_err;
    logic [7:0] resp_rdata;
    logic       busy;
    logic [3:0] m_cmd;
    logic [7:0] m_tx_data;
    logic       m_ready;
    logic [7:0] m_rx_data;
    logic       m_abort;

    modport slave (
        input  req_valid, req_rw, req_dev_addr, req_reg_addr, req_wdata, m_ready, m_rx_data,
        output req_ready, resp_valid, resp_err, resp_rdata, busy, m_cmd, m_tx_data, m_abort
    );

    modport master (
        output req_valid, req_rw, req_dev_addr, req_reg_addr, req_wdata, m_ready, m_rx_data,
        input  req_ready, resp_valid, resp_err, resp_rdata, busy, m_cmd, m_tx_data, m_abort
    );
endinterface

// File: rtl/i2c_reg_access_ctrl.sv
// Register-access sequencer: turns one read/write request into the START / WR / RESTART /
// RD / STOP command sequence for the byte-level I2C master, with a per-step watchdog.
module i2c_reg_access_ctrl #(
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic                  clk,
    input  logic                  reset,
    i2c_reg_access_ctrl_if.slave  bus
);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

    localparam logic [3:0] CMD_IDLE    = 4'd0;
    localparam logic [3:0] CMD_START   = 4'd1;
    localparam logic [3:0] CMD_STOP    = 4'd2;
    localparam logic [3:0] CMD_RESTART = 4'd3;
    localparam logic [3:0] CMD_RD      = 4'd4;
    localparam logic [3:0] CMD_WR      = 4'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACC,
        S_WAIT_DONE,
        S_RESP,
        S_ABORT
    } state_t;

    state_t        state_q;
    logic          rw_q;
    logic [6:0]    dev_q;
    logic [7:0]    reg_q;
    logic [7:0]    wdata_q;
    logic [2:0]    step_q;
    logic [TW-1:0] timer_q;
    logic          req_ready_q;
    logic          busy_q;
    logic          resp_valid_q;
    logic          resp_err_q;
    logic [7:0]    rdata_q;
    logic [7:0]    tx_q;
    logic          abort_q;

    logic [3:0]    step_cmd;
    logic [7:0]    step_data;
    logic          step_last;
    logic          timeout;
    logic          issue;

    // Decode the current step into a master command and its byte; non-WR steps keep the held byte.
    always_comb begin
        step_cmd  = CMD_IDLE;
        step_data = tx_q;
        case (step_q)
            3'd0: step_cmd = CMD_START;
            3'd1: begin
                step_cmd  = CMD_WR;
                step_data = {dev_q, 1'b0};
            end
            3'd2: begin
                step_cmd  = CMD_WR;
                step_data = reg_q;
            end
            3'd3: begin
                if (rw_q) begin
                    step_cmd = CMD_RESTART;
                end else begin
                    step_cmd  = CMD_WR;
                    step_data = wdata_q;
                end
            end
            3'd4: begin
                if (rw_q) begin
                    step_cmd  = CMD_WR;
                    step_data = {dev_q, 1'b1};
                end else begin
                    step_cmd = CMD_STOP;
                end
            end
            3'd5: step_cmd = CMD_RD;
            default: step_cmd = CMD_IDLE;
        endcase
    end

    // Reads end on RD (the master NACKs and stops on its own); writes end on STOP.
    assign step_last = rw_q ? (step_q == 3'd5) : (step_q == 3'd4);
    assign timeout   = (timer_q == TIMER_LAST);
    // The command strobe lives only in the cycle the master reports ready.
    assign issue     = (state_q == S_ISSUE) && bus.m_ready && !timeout;

    assign bus.m_cmd      = issue ? step_cmd : CMD_IDLE;
    assign bus.m_tx_data  = issue ? step_data : tx_q;
    assign bus.req_ready  = req_ready_q;
    assign bus.busy       = busy_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.m_abort    = abort_q;

    // Sequencer state machine with registered handshake/response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rw_q         <= 1'b0;
            dev_q        <= '0;
            reg_q        <= '0;
            wdata_q      <= '0;
            step_q       <= '0;
            timer_q      <= '0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rdata_q      <= '0;
            tx_q         <= '0;
            abort_q      <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            abort_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        rw_q        <= bus.req_rw;
                        dev_q       <= bus.req_dev_addr;
                        reg_q       <= bus.req_reg_addr;
                        wdata_q     <= bus.req_wdata;
                        step_q      <= '0;
                        timer_q     <= '0;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE, S_WAIT_ACC, S_WAIT_DONE: begin
                    timer_q <= timer_q + 1'b1;
                    if (timeout) begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        abort_q      <= 1'b1;
                        state_q      <= S_ABORT;
                    end else if (state_q == S_ISSUE) begin
                        if (bus.m_ready) begin
                            tx_q    <= step_data;
                            state_q <= S_WAIT_ACC;
                        end
                    end else if (state_q == S_WAIT_ACC) begin
                        // Master leaving IDLE/HOLD confirms it took the command.
                        if (!bus.m_ready) begin
                            state_q <= S_WAIT_DONE;
                        end
                    end else begin
                        if (bus.m_ready) begin
                            if (step_cmd == CMD_RD) begin
                                rdata_q <= bus.m_rx_data;
                            end
                            if (step_last) begin
                                resp_valid_q <= 1'b1;
                                resp_err_q   <= 1'b0;
                                state_q      <= S_RESP;
                            end else begin
                                step_q  <= step_q + 3'd1;
                                timer_q <= '0;
                                state_q <= S_ISSUE;
                            end
                        end
                    end
                end
                S_RESP, S_ABORT: begin
                    resp_err_q  <= 1'b0;
                    busy_q      <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_reg_access_ctrl.sv
// Directed bench for i2c_reg_access_ctrl with a simple behavioural byte-master/slave model.
module tb_i2c_reg_access_ctrl;
    localparam int TIMEOUT_CYC = 20000;
    localparam int MDELAY      = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    i2c_reg_access_ctrl_if bus();

    i2c_reg_access_ctrl #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Master/slave model controls
    logic       nack_mode  = 1'b0;
    logic [7:0] slave_byte = 8'h00;
    logic       dead       = 1'b0;
    int         busy_cnt   = 0;

    // Monitor records
    logic [3:0] cmd_log [128];
    logic [7:0] data_log[128];
    int         log_n          = 0;
    int         last_issue_cyc = 0;
    int         bad_cmd        = 0;
    int         resp_cnt       = 0;
    int         rise_cyc       = 0;
    logic       prev_ready     = 1'b0;

    // Byte master: ready drops for MDELAY cycles per accepted command; after a NACK of 0xA0
    // it parks in IDLE and ignores further commands until reset/abort.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset || bus.m_abort === 1'b1) begin
            bus.m_ready   <= 1'b1;
            bus.m_rx_data <= 8'h00;
            busy_cnt      <= 0;
            dead          <= 1'b0;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) bus.m_ready <= 1'b1;
        end else if (bus.m_cmd != 4'd0 && bus.m_ready && !dead) begin
            bus.m_ready <= 1'b0;
            busy_cnt    <= MDELAY;
            if (bus.m_cmd == 4'd4) bus.m_rx_data <= slave_byte;
            if (nack_mode && bus.m_cmd == 4'd5 && bus.m_tx_data == 8'hA0) dead <= 1'b1;
        end
    end

    // Negedge monitor: command log, ready rises, response pulses
    always @(negedge clk) begin
        prev_ready <= bus.m_ready;
        if (bus.m_ready === 1'b1 && prev_ready !== 1'b1) rise_cyc <= cyc;
        if (bus.resp_valid === 1'b1) begin
            resp_cnt <= resp_cnt + 1;
            $display("TXN cyc=%0d err=%0d rdata=%02h abort=%0d", cyc, bus.resp_err, bus.resp_rdata, bus.m_abort);
        end
        if (!reset && bus.m_cmd !== 4'd0) begin
            if (log_n < 128) begin
                cmd_log[log_n]  <= bus.m_cmd;
                data_log[log_n] <= bus.m_tx_data;
            end
            log_n          <= log_n + 1;
            last_issue_cyc <= cyc;
            if (bus.m_ready !== 1'b1) bad_cmd <= bad_cmd + 1;
        end
    end

    task automatic do_request(input logic rw, input logic [6:0] dev, input logic [7:0] ra,
                              input logic [7:0] wd, input int limit,
                              output logic ok, output logic err, output logic [7:0] rd,
                              output logic abort, output logic [3:0] first_cmd, output int done_cyc);
        int n;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        bus.req_rw       = rw;
        bus.req_dev_addr = dev;
        bus.req_reg_addr = ra;
        bus.req_wdata    = wd;
        bus.req_valid    = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        first_cmd     = bus.m_cmd;
        n = 0;
        while (bus.resp_valid !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        ok       = (bus.resp_valid === 1'b1);
        err      = bus.resp_err;
        rd       = bus.resp_rdata;
        abort    = bus.m_abort;
        done_cyc = cyc;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checks++; if (bus.req_ready !== 1'b1)   begin errors++; $display("FAIL rst_req_ready got %b exp 1", bus.req_ready); end
        checks++; if (bus.resp_valid !== 1'b0)  begin errors++; $display("FAIL rst_resp_valid got %b exp 0", bus.resp_valid); end
        checks++; if (bus.resp_err !== 1'b0)    begin errors++; $display("FAIL rst_resp_err got %b exp 0", bus.resp_err); end
        checks++; if (bus.resp_rdata !== 8'h00) begin errors++; $display("FAIL rst_resp_rdata got %h exp 00", bus.resp_rdata); end
        checks++; if (bus.busy !== 1'b0)        begin errors++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
        checks++; if (bus.m_cmd !== 4'd0)       begin errors++; $display("FAIL rst_m_cmd got %0d exp 0", bus.m_cmd); end
        checks++; if (bus.m_tx_data !== 8'h00)  begin errors++; $display("FAIL rst_m_tx_data got %h exp 00", bus.m_tx_data); end
        checks++; if (bus.m_abort !== 1'b0)     begin errors++; $display("FAIL rst_m_abort got %b exp 0", bus.m_abort); end
    endtask

    task automatic test_write();
        logic [3:0] exp_cmd[5] = '{4'd1, 4'd5, 4'd5, 4'd5, 4'd2};
        int base, rbase, dc;
        logic ok, err, ab;
        logic [7:0] rd;
        logic [3:0] fc;
        base  = log_n;
        rbase = resp_cnt;
        do_request(1'b0, 7'h50, 8'h10, 8'hA5, 500, ok, err, rd, ab, fc, dc);
        checks++; if (!ok)          begin errors++; $display("FAIL wr_resp got none exp resp_valid"); end
        checks++; if (fc !== 4'd1)  begin errors++; $display("FAIL wr_first_cmd got %0d exp 1", fc); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL wr_err got %b exp 0", err); end
        checks++; if (log_n - base != 5) begin errors++; $display("FAIL wr_cmd_count got %0d exp 5", log_n - base); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (cmd_log[base+i] !== exp_cmd[i]) begin
                errors++; $display("FAIL wr_cmd[%0d] got %0d exp %0d", i, cmd_log[base+i], exp_cmd[i]);
            end
        end
        checks++; if (data_log[base+1] !== 8'hA0) begin errors++; $display("FAIL wr_byte_dev got %h exp A0", data_log[base+1]); end
        checks++; if (data_log[base+2] !== 8'h10) begin errors++; $display("FAIL wr_byte_reg got %h exp 10", data_log[base+2]); end
        checks++; if (data_log[base+3] !== 8'hA5) begin errors++; $display("FAIL wr_byte_data got %h exp A5", data_log[base+3]); end
        checks++; if (dc != rise_cyc + 1) begin errors++; $display("FAIL wr_resp_latency got %0d exp %0d", dc, rise_cyc + 1); end
        checks++; if (resp_cnt - rbase != 1) begin errors++; $display("FAIL wr_resp_pulses got %0d exp 1", resp_cnt - rbase); end
    endtask

    task automatic test_read();
        logic [3:0] exp_cmd[6] = '{4'd1, 4'd5, 4'd5, 4'd3, 4'd5, 4'd4};
        int base, dc;
        logic ok, err, ab;
        logic [7:0] rd;
        logic [3:0] fc;
        base       = log_n;
        slave_byte = 8'h3C;
        do_request(1'b1, 7'h50, 8'h20, 8'hFF, 500, ok, err, rd, ab, fc, dc);
        checks++; if (!ok)          begin errors++; $display("FAIL rd_resp got none exp resp_valid"); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rd_err got %b exp 0", err); end
        checks++; if (rd !== 8'h3C) begin errors++; $display("FAIL rd_rdata got %h exp 3C", rd); end
        checks++; if (log_n - base != 6) begin errors++; $display("FAIL rd_cmd_count got %0d exp 6", log_n - base); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (cmd_log[base+i] !== exp_cmd[i]) begin
                errors++; $display("FAIL rd_cmd[%0d] got %0d exp %0d", i, cmd_log[base+i], exp_cmd[i]);
            end
        end
        checks++; if (data_log[base+1] !== 8'hA0) begin errors++; $display("FAIL rd_byte_dev got %h exp A0", data_log[base+1]); end
        checks++; if (data_log[base+2] !== 8'h20) begin errors++; $display("FAIL rd_byte_reg got %h exp 20", data_log[base+2]); end
        checks++; if (data_log[base+4] !== 8'hA1) begin errors++; $display("FAIL rd_byte_devr got %h exp A1", data_log[base+4]); end
        checks++; if (dc != rise_cyc + 1) begin errors++; $display("FAIL rd_resp_latency got %0d exp %0d", dc, rise_cyc + 1); end
    endtask

    task automatic test_nack_timeout();
        int base, dc;
        logic ok, err, ab;
        logic [7:0] rd;
        logic [3:0] fc;
        base      = log_n;
        nack_mode = 1'b1;
        do_request(1'b0, 7'h50, 8'h11, 8'h99, 25000, ok, err, rd, ab, fc, dc);
        nack_mode = 1'b0;
        checks++; if (!ok)          begin errors++; $display("FAIL nack_resp got none exp resp_valid"); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL nack_err got %b exp 1", err); end
        checks++; if (ab !== 1'b1)  begin errors++; $display("FAIL nack_abort got %b exp 1", ab); end
        checks++; if (rd !== 8'h3C) begin errors++; $display("FAIL nack_rdata got %h exp 3C", rd); end
        checks++; if (log_n - base != 3) begin errors++; $display("FAIL nack_cmd_count got %0d exp 3", log_n - base); end
        checks++; if (data_log[base+2] !== 8'h11) begin errors++; $display("FAIL nack_last_byte got %h exp 11", data_log[base+2]); end
        checks++; if (dc - last_issue_cyc != TIMEOUT_CYC) begin
            errors++; $display("FAIL nack_timeout_cycles got %0d exp %0d", dc - last_issue_cyc, TIMEOUT_CYC);
        end
        checks++; if (bus.m_abort !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL nack_after got abort=%b ready=%b exp abort=0 ready=1", bus.m_abort, bus.req_ready);
        end
    endtask

    task automatic test_busy_hold();
        int base, n, viol;
        base = log_n;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        bus.req_rw       = 1'b0;
        bus.req_dev_addr = 7'h50;
        bus.req_reg_addr = 8'h30;
        bus.req_wdata    = 8'h11;
        bus.req_valid    = 1'b1;
        @(negedge clk);
        bus.req_reg_addr = 8'h31;
        bus.req_wdata    = 8'h22;
        n = 0;
        viol = 0;
        while (bus.resp_valid !== 1'b1 && n < 500) begin
            if (bus.req_ready !== 1'b0) viol++;
            @(negedge clk);
            n++;
        end
        checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL hold_first_resp got none exp resp_valid"); end
        checks++; if (viol != 0 || bus.req_ready !== 1'b0) begin
            errors++; $display("FAIL hold_ready_low got %0d high cycles exp 0", viol);
        end
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL hold_ready_after got %b exp 1", bus.req_ready); end
        @(negedge clk);
        checks++; if (bus.busy !== 1'b1 || bus.req_ready !== 1'b0) begin
            errors++; $display("FAIL hold_second_accept got busy=%b ready=%b exp busy=1 ready=0", bus.busy, bus.req_ready);
        end
        bus.req_valid = 1'b0;
        n = 0;
        while (bus.resp_valid !== 1'b1 && n < 500) begin @(negedge clk); n++; end
        checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL hold_second_resp got none exp resp_valid"); end
        @(negedge clk);
        checks++; if (log_n - base != 10) begin errors++; $display("FAIL hold_cmd_count got %0d exp 10", log_n - base); end
        checks++; if (data_log[base+3] !== 8'h11 || data_log[base+7] !== 8'h31 || data_log[base+8] !== 8'h22) begin
            errors++; $display("FAIL hold_bytes got %h %h %h exp 11 31 22", data_log[base+3], data_log[base+7], data_log[base+8]);
        end
    endtask

    task automatic test_reset_mid();
        int base, rc, n, dc;
        logic ok, err, ab;
        logic [7:0] rd;
        logic [3:0] fc;
        base = log_n;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        bus.req_rw       = 1'b0;
        bus.req_dev_addr = 7'h50;
        bus.req_reg_addr = 8'h40;
        bus.req_wdata    = 8'h77;
        bus.req_valid    = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (log_n < base + 4 && n < 200) begin @(negedge clk); n++; end
        checks++; if (log_n < base + 4) begin errors++; $display("FAIL mid_reach_step3 got %0d cmds exp 4", log_n - base); end
        rc    = resp_cnt;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL mid_idle got ready=%b busy=%b exp ready=1 busy=0", bus.req_ready, bus.busy);
        end
        checks++; if (bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0 || bus.m_abort !== 1'b0) begin
            errors++; $display("FAIL mid_resp got valid=%b err=%b abort=%b exp 0 0 0", bus.resp_valid, bus.resp_err, bus.m_abort);
        end
        checks++; if (bus.m_cmd !== 4'd0 || bus.m_tx_data !== 8'h00 || bus.resp_rdata !== 8'h00) begin
            errors++; $display("FAIL mid_outputs got cmd=%0d tx=%h rdata=%h exp 0 00 00", bus.m_cmd, bus.m_tx_data, bus.resp_rdata);
        end
        repeat (3) @(negedge clk);
        checks++; if (resp_cnt != rc) begin errors++; $display("FAIL mid_no_resp got %0d pulses exp 0", resp_cnt - rc); end
        base = log_n;
        do_request(1'b0, 7'h50, 8'h41, 8'h78, 500, ok, err, rd, ab, fc, dc);
        checks++; if (!ok || err !== 1'b0) begin errors++; $display("FAIL mid_fresh got ok=%b err=%b exp ok=1 err=0", ok, err); end
        checks++; if (log_n - base != 5 || cmd_log[base+4] !== 4'd2 || data_log[base+3] !== 8'h78) begin
            errors++; $display("FAIL mid_fresh_seq got %0d cmds last=%0d data=%h exp 5 2 78", log_n - base, cmd_log[base+4], data_log[base+3]);
        end
    endtask

    task automatic test_back_to_back();
        int dc;
        logic ok, err, ab;
        logic [7:0] rd;
        logic [3:0] fc;
        slave_byte = 8'h5A;
        do_request(1'b1, 7'h50, 8'h21, 8'h00, 500, ok, err, rd, ab, fc, dc);
        checks++; if (!ok || rd !== 8'h5A) begin errors++; $display("FAIL b2b_read got ok=%b rdata=%h exp 1 5A", ok, rd); end
        do_request(1'b0, 7'h50, 8'h22, 8'h01, 500, ok, err, rd, ab, fc, dc);
        checks++; if (!ok || err !== 1'b0) begin errors++; $display("FAIL b2b_write got ok=%b err=%b exp 1 0", ok, err); end
        checks++; if (rd !== 8'h5A) begin errors++; $display("FAIL b2b_rdata_hold got %h exp 5A", rd); end
    endtask

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_rw       = 1'b0;
        bus.req_dev_addr = 7'h00;
        bus.req_reg_addr = 8'h00;
        bus.req_wdata    = 8'h00;
        @(negedge clk);
        test_reset();
        test_write();
        test_read();
        test_nack_timeout();
        test_busy_hold();
        test_reset_mid();
        test_back_to_back();
        checks++; if (bad_cmd != 0) begin errors++; $display("FAIL cmd_without_ready got %0d exp 0", bad_cmd); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end
endmodule
